// File: rtl/beat_classify_ctrl.sv
// Purpose : sequences CLEAR/RUN windows over BEATS beats and picks the run's majority spike class.
// Latency : CLR_CYCLES + up to WINDOW + 1 cycles per beat; result registered one cycle after the last beat closes.
// Backpressure: res_valid/class_out hold in DONE until res_ready; start is ignored (not queued) while busy.
//
// Ports:
//   clk, resetn          clock; synchronous reset, active HIGH despite the name
//   start                run request, only looked at in IDLE
//   spike_valid/class_in arbitrator spike flag and class code, only looked at in RUN
//   net_clear            held high while the network/arbitrator are being cleared before each beat
//   busy                 high whenever not IDLE
//   beat_done/beat_class one-cycle pulse and recorded class when a beat window closes
//   timeout              one-cycle pulse when a beat window closes without any spike
//   res_valid/res_ready  result handshake; class_out is the majority class of the run
module beat_classify_ctrl #(
    parameter int unsigned WINDOW     = 1500000,
    parameter int unsigned CLR_CYCLES = 4,
    parameter int unsigned BEATS      = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       spike_valid,
    input  logic [1:0] class_in,
    output logic       net_clear,
    output logic       busy,
    output logic       beat_done,
    output logic [1:0] beat_class,
    output logic       timeout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [1:0] class_out
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Wide enough to count every beat into one class without wrapping.
    localparam int TAL_W = $clog2(BEATS + 1);

    localparam logic [WIN_W-1:0] WIN_LOAD  = WIN_W'(WINDOW - 1);
    localparam logic [CLR_W-1:0] CLR_LOAD  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
    logic [CLR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [BC_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic [TAL_W-1:0]   tally     [4];
    logic [TAL_W-1:0]   tally_nxt [4];

    logic               net_clear_nxt;
    logic               busy_nxt;
    logic               beat_done_nxt;
    logic [1:0]         beat_class_nxt;
    logic               timeout_nxt;
    logic               res_valid_nxt;
    logic [1:0]         class_out_nxt;

    logic               win_close;
    logic [1:0]         best;
    logic [1:0]         majority;

    // A spike on the final window cycle still counts as a spike.
    assign win_close = spike_valid || (win_cnt == '0);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= S_IDLE;
            win_cnt    <= '0;
            clr_cnt    <= '0;
            beat_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                tally[i] <= '0;
            end
            net_clear  <= 1'b0;
            busy       <= 1'b0;
            beat_done  <= 1'b0;
            beat_class <= 2'd0;
            timeout    <= 1'b0;
            res_valid  <= 1'b0;
            class_out  <= 2'd0;
        end else begin
            state      <= state_nxt;
            win_cnt    <= win_cnt_nxt;
            clr_cnt    <= clr_cnt_nxt;
            beat_cnt   <= beat_cnt_nxt;
            for (int i = 0; i < 4; i++) begin
                tally[i] <= tally_nxt[i];
            end
            net_clear  <= net_clear_nxt;
            busy       <= busy_nxt;
            beat_done  <= beat_done_nxt;
            beat_class <= beat_class_nxt;
            timeout    <= timeout_nxt;
            res_valid  <= res_valid_nxt;
            class_out  <= class_out_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: if (clr_cnt == '0) state_nxt = S_RUN;
            S_RUN:   if (win_close) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = (beat_cnt == BEAT_LAST) ? S_DONE : S_CLEAR;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Majority vote: best of classes 1..3 with ties to the lowest index;
    // class 0 only wins by strictly beating that.
    always_comb begin
        best = 2'd1;
        for (int c = 2; c < 4; c++) begin
            if (tally[c] > tally[best]) best = 2'(c);
        end
        majority = (tally[0] > tally[best]) ? 2'd0 : best;
    end

    // Counters, tallies and next values of the registered outputs.
    always_comb begin
        win_cnt_nxt    = win_cnt;
        clr_cnt_nxt    = clr_cnt;
        beat_cnt_nxt   = beat_cnt;
        tally_nxt      = tally;
        beat_done_nxt  = 1'b0;
        beat_class_nxt = beat_class;
        timeout_nxt    = 1'b0;
        class_out_nxt  = class_out;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    beat_cnt_nxt = '0;
                    clr_cnt_nxt  = CLR_LOAD;
                    for (int i = 0; i < 4; i++) begin
                        tally_nxt[i] = '0;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_cnt == '0) begin
                    win_cnt_nxt = WIN_LOAD;
                end else begin
                    clr_cnt_nxt = clr_cnt - CLR_W'(1);
                end
            end
            S_RUN: begin
                if (spike_valid) begin
                    tally_nxt[class_in] = tally[class_in] + TAL_W'(1);
                    beat_class_nxt      = class_in;
                    beat_done_nxt       = 1'b1;
                end else if (win_cnt == '0) begin
                    tally_nxt[0]   = tally[0] + TAL_W'(1);
                    beat_class_nxt = 2'd0;
                    beat_done_nxt  = 1'b1;
                    timeout_nxt    = 1'b1;
                end else begin
                    win_cnt_nxt = win_cnt - WIN_W'(1);
                end
            end
            S_NEXT: begin
                if (beat_cnt == BEAT_LAST) begin
                    class_out_nxt = majority;
                end else begin
                    beat_cnt_nxt = beat_cnt + BC_W'(1);
                    clr_cnt_nxt  = CLR_LOAD;
                end
            end
            S_DONE: begin
                if (res_ready) class_out_nxt = 2'd0;
            end
            default: ;
        endcase

        // Level outputs follow the state being entered, so they are registered
        // yet aligned with the state they describe.
        net_clear_nxt = (state_nxt == S_CLEAR);
        busy_nxt      = (state_nxt != S_IDLE);
        res_valid_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_beat_classify_ctrl.sv
// Purpose : directed + randomized bench for beat_classify_ctrl against a per-run beat plan model.
// Latency : expectations are derived from the beat plan (clear, window, next, done phase lengths).
// Backpressure: holds res_ready low for a chosen number of DONE cycles while pulsing start.
module tb_beat_classify_ctrl;

    localparam int WIN = 20;
    localparam int CLR = 2;
    localparam int NB  = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       spike_valid;
    logic [1:0] class_in;
    logic       net_clear;
    logic       busy;
    logic       beat_done;
    logic [1:0] beat_class;
    logic       timeout;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] class_out;

    int n_cmp = 0;
    int n_err = 0;

    // Beat plan: RUN cycle (1..WIN) on which a spike is driven, 0 = no spike.
    int         plan_at  [NB];
    logic [1:0] plan_cls [NB];

    beat_classify_ctrl #(
        .WINDOW     (WIN),
        .CLR_CYCLES (CLR),
        .BEATS      (NB)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .spike_valid (spike_valid),
        .class_in    (class_in),
        .net_clear   (net_clear),
        .busy        (busy),
        .beat_done   (beat_done),
        .beat_class  (beat_class),
        .timeout     (timeout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .class_out   (class_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_net_clear"},  32'(net_clear),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_beat_done"},  32'(beat_done),  0);
        check({tag, "_beat_class"}, 32'(beat_class), 0);
        check({tag, "_timeout"},    32'(timeout),    0);
        check({tag, "_res_valid"},  32'(res_valid),  0);
        check({tag, "_class_out"},  32'(class_out),  0);
    endtask

    task automatic noise(input bit allow_start);
        spike_valid = 1'($urandom_range(0, 1));
        class_in    = 2'($urandom_range(0, 3));
        start       = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic set_plan(input int a0, input int c0, input int a1, input int c1,
                            input int a2, input int c2);
        plan_at[0] = a0; plan_cls[0] = 2'(c0);
        plan_at[1] = a1; plan_cls[1] = 2'(c1);
        plan_at[2] = a2; plan_cls[2] = 2'(c2);
    endtask

    task automatic random_plan();
        for (int b = 0; b < NB; b++) begin
            plan_at[b]  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, WIN));
            plan_cls[b] = 2'($urandom_range(0, 3));
        end
    endtask

    // One full run following the current plan; entered and left at a negedge in IDLE.
    task automatic do_run(input int hold, input bit rst_in_done);
        int         cnt [4];
        int         best;
        int         len;
        logic [1:0] exp_cls;
        logic [1:0] exp_bc;

        // Expected vote: count each beat's class (timeout counts as class 0).
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int b = 0; b < NB; b++) begin
            if (plan_at[b] == 0) cnt[0]++;
            else cnt[plan_cls[b]]++;
        end
        best = 1;
        for (int c = 2; c < 4; c++) if (cnt[c] > cnt[best]) best = c;
        exp_cls = (cnt[0] > cnt[best]) ? 2'd0 : 2'(best);

        start       = 1'b1;
        spike_valid = 1'b0;
        res_ready   = 1'b0;
        @(negedge clk);

        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < CLR; c++) begin
                check("clr_net_clear", 32'(net_clear), 1);
                check("clr_busy",      32'(busy),      1);
                check("clr_beat_done", 32'(beat_done), 0);
                check("clr_timeout",   32'(timeout),   0);
                noise(1'b1);
                @(negedge clk);
            end
            len = (plan_at[b] == 0) ? WIN : plan_at[b];
            for (int n = 1; n <= len; n++) begin
                check("run_net_clear", 32'(net_clear), 0);
                check("run_busy",      32'(busy),      1);
                check("run_beat_done", 32'(beat_done), 0);
                check("run_timeout",   32'(timeout),   0);
                start       = 1'($urandom_range(0, 1));
                spike_valid = (n == plan_at[b]);
                class_in    = (n == plan_at[b]) ? plan_cls[b] : 2'($urandom_range(0, 3));
                @(negedge clk);
            end
            exp_bc = (plan_at[b] == 0) ? 2'd0 : plan_cls[b];
            check("next_beat_done",  32'(beat_done),  1);
            check("next_beat_class", 32'(beat_class), 32'(exp_bc));
            check("next_timeout",    32'(timeout),    32'(plan_at[b] == 0));
            check("next_net_clear",  32'(net_clear),  0);
            check("next_busy",       32'(busy),       1);
            noise(1'b1);
            @(negedge clk);
        end

        for (int h = 0; h < hold; h++) begin
            check("hold_res_valid", 32'(res_valid), 1);
            check("hold_class_out", 32'(class_out), 32'(exp_cls));
            check("hold_beat_done", 32'(beat_done), 0);
            check("hold_net_clear", 32'(net_clear), 0);
            noise(1'b1);
            res_ready = 1'b0;
            @(negedge clk);
        end
        check("done_res_valid", 32'(res_valid), 1);
        check("done_class_out", 32'(class_out), 32'(exp_cls));
        check("done_busy",      32'(busy),      1);
        start = 1'b0;

        if (rst_in_done) begin
            resetn = 1'b1;
            @(negedge clk);
            check_quiet("done_rst");
            resetn = 1'b0;
        end else begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("ack_res_valid", 32'(res_valid), 0);
            check("ack_busy",      32'(busy),      0);
        end

        // Start pulses seen while busy must not have been queued.
        for (int i = 0; i < 3; i++) begin
            noise(1'b0);
            @(negedge clk);
            check("post_busy",      32'(busy),      0);
            check("post_res_valid", 32'(res_valid), 0);
            check("post_net_clear", 32'(net_clear), 0);
        end
    endtask

    initial begin
        resetn      = 1'b1;
        start       = 1'b0;
        spike_valid = 1'b0;
        class_in    = 2'd0;
        res_ready   = 1'b0;

        // Reset held two cycles with arbitrary inputs.
        for (int i = 0; i < 2; i++) begin
            noise(1'b1);
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_quiet("reset");
        end
        resetn    = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        check_quiet("idle");

        // Spike of class 2 at RUN cycle 5 every beat.
        set_plan(5, 2, 5, 2, 5, 2);
        do_run(0, 1'b0);

        // No spikes: three full windows, all timeouts.
        set_plan(0, 0, 0, 0, 0, 0);
        do_run(1, 1'b0);

        // Classes 3,1,0: three-way tie resolves to class 1.
        set_plan(4, 3, 9, 1, 12, 0);
        do_run(0, 1'b0);

        // Classes 0 (timeout), 0 (spike), 2: class 0 strictly ahead.
        set_plan(0, 0, 7, 0, 3, 2);
        do_run(2, 1'b0);

        // Spike on the last window cycle counts as a spike, not a timeout.
        set_plan(WIN, 3, WIN, 3, 0, 0);
        do_run(0, 1'b0);

        // Result held ten cycles under start pulses.
        random_plan();
        do_run(10, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            random_plan();
            do_run(int'($urandom_range(0, 4)), 1'b0);
        end

        // Reset while in DONE discards the result.
        random_plan();
        do_run(3, 1'b1);

        // Reset mid-RUN: back to IDLE next cycle, no result ever appears.
        start       = 1'b1;
        spike_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < CLR + 7; i++) @(negedge clk);
        check("midrun_busy", 32'(busy), 1);
        resetn = 1'b1;
        @(negedge clk);
        check_quiet("midrun_rst");
        resetn = 1'b0;
        for (int i = 0; i < WIN + 5; i++) begin
            spike_valid = 1'($urandom_range(0, 1));
            class_in    = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("after_rst_res_valid", 32'(res_valid), 0);
            check("after_rst_busy",      32'(busy),      0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/beat_classify_ctrl.md
BEAT_CLASSIFY_CTRL -- requirements
Module: beat_classify_ctrl

Parameters
REQ-001 WINDOW, default 1500000: RUN-state cycles per beat before a no-spike timeout.
REQ-002 CLR_CYCLES, default 4: cycles net_clear is held high before each beat window.
REQ-003 BEATS, default 4: beat windows per classification run, legal range 1..15.

Interface
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 resetn  input  1  synchronous, active-high reset, despite the name.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 spike_valid  input  1  arbitrator spike-present flag for this cycle.
REQ-008 class_in  input  2  arbitrator class code; valid when spike_valid=1.
REQ-009 net_clear  output  1  clears and reloads the spiking network and arbitrator.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 beat_done  output  1  one-cycle pulse when a beat window closes.
REQ-012 beat_class  output  2  class recorded for the closing beat; valid with beat_done.
REQ-013 timeout  output  1  one-cycle pulse when a beat window closes with no spike.
REQ-014 res_valid  output  1  run result available.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 class_out  output  2  majority class of the run; valid while res_valid=1.

Function
REQ-017 FSM states shall be IDLE, CLEAR, RUN, NEXT and DONE; all outputs are registered.
REQ-018 IDLE: start=1 -> CLEAR; tallies and beat_cnt zeroed on the same edge.
REQ-019 CLEAR: net_clear=1 for exactly CLR_CYCLES consecutive cycles, starting the cycle after the start edge; then -> RUN with win_cnt=WINDOW-1.
REQ-020 RUN: net_clear=0; with spike_valid=1, tally[class_in]+1 and beat_class=class_in; class_in=0 counts as tally[0].
REQ-021 RUN: with spike_valid=0 and win_cnt=0, tally[0]+1, beat_class=0 and timeout pulses; otherwise win_cnt decrements.
REQ-022 RUN: spike_valid=1 together with win_cnt=0 counts as a spike; timeout stays low.
REQ-023 RUN -> NEXT on the cycle the window closes; beat_done pulses in the first NEXT cycle.
REQ-024 NEXT, one cycle: if beat_cnt=BEATS-1 -> DONE, otherwise beat_cnt+1 -> CLEAR, re-clearing the network each beat.
REQ-025 Tally width shall be clog2(BEATS+1) bits; tallies never saturate or wrap within legal BEATS.
REQ-026 Result: highest tally among classes 1..3, ties to lowest index; class 0 wins only if tally[0] strictly exceeds every other tally.
REQ-027 DONE: res_valid=1 and class_out stay stable until res_ready=1; on that edge -> IDLE and res_valid=0 next cycle.
REQ-028 start shall be ignored in every state except IDLE, and shall not be queued.
REQ-029 spike_valid and class_in shall be ignored outside RUN.
REQ-030 Outputs timeout and beat_done shall never be high in the same cycle as net_clear.

Reset
REQ-031 resetn=1 at any edge shall force IDLE and clear tallies, beat_cnt and win_cnt.
REQ-032 During reset, all outputs shall be 0: net_clear, busy, beat_done, beat_class, timeout, res_valid and class_out.
REQ-033 Reset mid-run or mid-DONE shall discard the partial result; no res_valid is produced.

Verification (WINDOW=20, CLR_CYCLES=2, BEATS=3)
REQ-034 Reset held 2 cycles, any inputs -> all outputs 0 and busy=0 the following cycle.
REQ-035 start at edge k; spike_valid=1 with class_in=2 at RUN cycle 5 of each beat -> net_clear high during cycles k+1..k+2, three beat_done pulses with beat_class=2, then res_valid=1 with class_out=2.
REQ-036 No spikes -> each RUN lasts 20 cycles, three timeout pulses, class_out=0.
REQ-037 Beat classes 3, 1, 0 -> tie resolved, class_out=1; beat classes 0, 0, 2 -> class_out=0.
REQ-038 spike_valid=1 with class_in=3 on the last RUN cycle (win_cnt=0) -> beat_class=3, no timeout pulse.
REQ-039 res_ready low for 10 cycles in DONE, with start pulses -> res_valid and class_out unchanged and no new run; resetn=1 mid-RUN -> IDLE next cycle, no res_valid.
